// File: rtl/tiny_rv_pkg.sv
// Shared types and encodings for the tiny RISC-V writeback stage.
package tiny_rv_pkg;

    // Load size/sign encodings carried in funct3.
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Writeback sequencer states.
    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

    // Context of a load captured at acceptance and used when data returns.
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } load_ctx_t;

    // True for the five funct3 values that name a real load.
    function automatic logic is_legal_load(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_legal_load = 1'b1;
            default:                             is_legal_load = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tiny_rv_load_ext.sv
// Combinational load alignment and sign/zero extension.
module tiny_rv_load_ext
    import tiny_rv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o,
    output logic        bad_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed byte and halfword out of the aligned word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        byte_lane = 8'h00;
        case (addr_lo_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            2'd3:    byte_lane = rdata_i[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend the selected lane according to the load size/sign.
    always_comb begin
        data_o = 32'h0000_0000;
        bad_o  = !is_legal_load(funct3_i);
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   data_o = {{16{half_lane[15]}}, half_lane};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'h00_0000, byte_lane};
            F3_LHU:  data_o = {16'h0000, half_lane};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/tiny_rv_wb.sv
// Writeback stage: retires ALU results with one cycle of latency, stalls the
// pipe while a load is outstanding, extends returning load data, and exposes
// two forwarding ports (this cycle's write and last cycle's write).
module tiny_rv_wb
    import tiny_rv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_stall,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [4:0]  of1_reg,
    output logic [31:0] of1_val,
    output logic [4:0]  of2_reg,
    output logic [31:0] of2_val,
    output logic [31:0] o_retire_cnt,
    output logic        o_err
);

    wb_state_e   state_q, state_d;
    load_ctx_t   ld_q, ld_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] retire_q, retire_d;
    logic        err_q, err_d;
    logic [4:0]  of2_reg_q;
    logic [31:0] of2_val_q;

    logic        accept;
    logic [31:0] ext_data;
    logic        ext_bad;

    tiny_rv_load_ext u_load_ext (
        .funct3_i  (ld_q.funct3),
        .addr_lo_i (ld_q.addr_lo),
        .rdata_i   (i_dmem_rdata),
        .data_o    (ext_data),
        .bad_o     (ext_bad)
    );

    // Upstream is held for every cycle a load is outstanding.
    assign o_wb_stall = (state_q == ST_WAIT_LOAD);
    assign accept     = ex_valid && !o_wb_stall;

    // Next-state and writeback selection.
    always_comb begin
        state_d   = state_q;
        ld_d      = ld_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        retire_d  = retire_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                // Read data with no load outstanding is a protocol error; drop it.
                if (i_dmem_rvalid) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    if (ex_is_load) begin
                        state_d = ST_WAIT_LOAD;
                        ld_d    = '{rd: ex_rd, funct3: ex_funct3, addr_lo: ex_addr_lo};
                    end else begin
                        wr_en_d   = (ex_rd != 5'd0);
                        wr_addr_d = ex_rd;
                        wr_data_d = ex_result;
                        retire_d  = retire_q + 32'd1;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                if (i_dmem_rvalid) begin
                    state_d   = ST_IDLE;
                    wr_en_d   = (ld_q.rd != 5'd0);
                    wr_addr_d = ld_q.rd;
                    wr_data_d = ext_data;
                    retire_d  = retire_q + 32'd1;
                    if (ext_bad) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, writeback and counter registers; reset abandons any pending load.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            ld_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'h0000_0000;
            retire_q  <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            ld_q      <= ld_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            retire_q  <= retire_d;
            err_q     <= err_d;
        end
    end

    // Newest forward mirrors the write port only while it is actually writing.
    assign of1_reg = wr_en_q ? wr_addr_q : 5'd0;
    assign of1_val = wr_en_q ? wr_data_q : 32'h0000_0000;

    // Previous-cycle forward covers a regfile read racing the write.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            of2_reg_q <= 5'd0;
            of2_val_q <= 32'h0000_0000;
        end else begin
            of2_reg_q <= of1_reg;
            of2_val_q <= of1_val;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign of2_reg      = of2_reg_q;
    assign of2_val      = of2_val_q;
    assign o_retire_cnt = retire_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_tiny_rv_wb.sv
// Directed self-checking bench for tiny_rv_wb with a writeback scoreboard.
module tb_tiny_rv_wb;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_result = 32'h0;
    logic        ex_is_load = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [1:0]  ex_addr_lo = 2'd0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = 32'h0;
    logic        o_wb_stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  of1_reg;
    logic [31:0] of1_val;
    logic [4:0]  of2_reg;
    logic [31:0] of2_val;
    logic [31:0] o_retire_cnt;
    logic        o_err;

    tiny_rv_wb dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .ex_is_load    (ex_is_load),
        .ex_funct3     (ex_funct3),
        .ex_addr_lo    (ex_addr_lo),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_wb_stall    (o_wb_stall),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .of1_reg       (of1_reg),
        .of1_val       (of1_val),
        .of2_reg       (of2_reg),
        .of2_val       (of2_val),
        .o_retire_cnt  (o_retire_cnt),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_wb_t;

    exp_wb_t     sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_cnt = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference load extension, written with shifts rather than lane muxes.
    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] alo,
                                              input logic [31:0] w);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> (8 * int'(alo));
        sh = w >> (16 * int'(alo[1]));
        case (f3)
            3'd0:    return {{24{sb[7]}}, sb[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd2:    return w;
            3'd4:    return {24'h0, sb[7:0]};
            3'd5:    return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"},  32'(o_wb_stall), 32'h0);
        chk({tag, "_wr_en"},  32'(wr_en),      32'h0);
        chk({tag, "_wr_addr"}, 32'(wr_addr),   32'h0);
        chk({tag, "_wr_data"}, wr_data,        32'h0);
        chk({tag, "_of1_reg"}, 32'(of1_reg),   32'h0);
        chk({tag, "_of1_val"}, of1_val,        32'h0);
        chk({tag, "_of2_reg"}, 32'(of2_reg),   32'h0);
        chk({tag, "_of2_val"}, of2_val,        32'h0);
        chk({tag, "_retire"},  o_retire_cnt,   32'h0);
        chk({tag, "_err"},     32'(o_err),     32'h0);
    endtask

    // Called on the negedge where a writeback is due: pop and compare, then
    // check the delayed forward and that the write happened only once.
    task automatic check_wb(input string tag);
        exp_wb_t e;
        chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        exp_cnt = exp_cnt + 32'd1;
        chk({tag, "_wr_en"},   32'(wr_en),   32'(e.en));
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(e.addr));
        if (e.en) chk({tag, "_wr_data"}, wr_data, e.data);
        chk({tag, "_of1_reg"}, 32'(of1_reg), e.en ? 32'(e.addr) : 32'h0);
        if (e.en) chk({tag, "_of1_val"}, of1_val, e.data);
        chk({tag, "_retire"}, o_retire_cnt, exp_cnt);
        @(negedge i_clk);
        chk({tag, "_of2_reg"}, 32'(of2_reg), e.en ? 32'(e.addr) : 32'h0);
        if (e.en) chk({tag, "_of2_val"}, of2_val, e.data);
        chk({tag, "_once"},       32'(wr_en),  32'h0);
        chk({tag, "_retire_hold"}, o_retire_cnt, exp_cnt);
    endtask

    task automatic do_alu(input string tag, input logic [4:0] rd, input logic [31:0] res);
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_result = res;
        sb_q.push_back('{en: (rd != 5'd0), addr: rd, data: res});
        @(posedge i_clk);
        @(negedge i_clk);
        ex_valid = 1'b0;
        check_wb(tag);
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] alo, input logic [31:0] rdata,
                           input int delay, input bit hold_ex);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_funct3 = f3;
        ex_addr_lo = alo; ex_result = 32'h0000_1000;
        sb_q.push_back('{en: (rd != 5'd0), addr: rd, data: ext_model(f3, alo, rdata)});
        @(posedge i_clk);
        @(negedge i_clk);
        // Optionally keep an ALU beat on the bus while stalled; it must be ignored.
        ex_valid = hold_ex; ex_is_load = 1'b0; ex_rd = 5'd31; ex_result = 32'hDEAD_BEEF;
        for (int i = 1; i <= delay; i++) begin
            chk({tag, "_stall"},   32'(o_wb_stall), 32'h1);
            chk({tag, "_nofwd"},   32'(of1_reg),    32'h0);
            if (i == delay) begin
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata  = rdata;
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end
        i_dmem_rvalid = 1'b0;
        ex_valid = 1'b0;
        chk({tag, "_unstall"}, 32'(o_wb_stall), 32'h0);
        check_wb(tag);
    endtask

    task automatic apply_reset(input string tag);
        i_reset_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        sb_q.delete();
        exp_cnt = 32'h0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        apply_reset("por");
        @(negedge i_clk);

        do_alu("alu_x5", 5'd5, 32'h0000_1234);
        do_alu("alu_x0", 5'd0, 32'h0BAD_F00D);

        do_load("lb_hi",  5'd10, 3'd0, 2'd3, 32'h80FF_FFFF, 3, 1'b1);
        do_load("lhu_hi", 5'd11, 3'd5, 2'd2, 32'hBEEF_0000, 1, 1'b0);
        do_load("lh_hi",  5'd12, 3'd1, 2'd2, 32'hBEEF_0000, 1, 1'b0);
        do_load("lw",     5'd13, 3'd2, 2'd0, 32'h1357_9BDF, 2, 1'b0);
        do_load("lbu_b1", 5'd14, 3'd4, 2'd1, 32'h1234_A5C3, 1, 1'b0);
        do_load("lb_b0",  5'd15, 3'd0, 2'd0, 32'h1234_A5C3, 2, 1'b0);
        do_load("lh_lo",  5'd16, 3'd1, 2'd0, 32'h0000_7FFF, 1, 1'b0);
        do_load("lw_x0",  5'd0,  3'd2, 2'd0, 32'hFFFF_FFFF, 1, 1'b0);
        chk("err_clean", 32'(o_err), 32'h0);

        do_load("bad_f3", 5'd7, 3'd3, 2'd1, 32'hFFFF_FFFF, 2, 1'b0);
        chk("bad_f3_err", 32'(o_err), 32'h1);

        // Stray read data in IDLE: flagged and dropped.
        apply_reset("rst_a");
        @(negedge i_clk);
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h5555_5555;
        @(posedge i_clk);
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        chk("stray_err",    32'(o_err),        32'h1);
        chk("stray_wr_en",  32'(wr_en),        32'h0);
        chk("stray_retire", o_retire_cnt,      32'h0);
        @(negedge i_clk);
        chk("stray_sticky", 32'(o_err),        32'h1);

        // Reset in the middle of an outstanding load.
        apply_reset("rst_b");
        do_alu("pre_rst", 5'd9, 32'hCAFE_0001);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd20; ex_funct3 = 3'd2; ex_addr_lo = 2'd0;
        @(posedge i_clk);
        @(negedge i_clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        chk("mid_stall", 32'(o_wb_stall), 32'h1);
        chk("mid_retire", o_retire_cnt, 32'h1);
        #2;
        apply_reset("rst_mid");
        @(negedge i_clk);
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h7777_7777;
        @(posedge i_clk);
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        chk("late_err",    32'(o_err),   32'h1);
        chk("late_wr_en",  32'(wr_en),   32'h0);
        chk("late_of1",    32'(of1_reg), 32'h0);
        chk("late_retire", o_retire_cnt, 32'h0);
        chk("late_stall",  32'(o_wb_stall), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tiny_rv_wb.md
TINY_RV_WB -- requirements
Module: tiny_rv_wb

Interface
REQ-001 SHALL have ports: i_clk  in  1  core clock, all state on rising edge.
REQ-002 SHALL have ports: i_reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: ex_valid  in  1  execute result present; ex_rd  in  5  destination; ex_result  in  32  ALU result or load address; ex_is_load  in  1  load op; ex_funct3  in  3  load size/sign; ex_addr_lo  in  2  load byte offset.
REQ-004 SHALL have ports: i_dmem_rvalid  in  1  load data strobe; i_dmem_rdata  in  32  aligned load word.
REQ-005 SHALL have ports: o_wb_stall  out  1  upstream hold; wr_en  out  1  regfile write; wr_addr  out  5; wr_data  out  32.
REQ-006 SHALL have ports: of1_reg/of1_val  out  5/32  newest forward; of2_reg/of2_val  out  5/32  previous-cycle forward.
REQ-007 SHALL have ports: o_retire_cnt  out  32  retired writebacks; o_err  out  1  sticky protocol/decode error.

Function
REQ-008 SHALL accept an ex_* beat when ex_valid=1 and o_wb_stall=0; otherwise ex_* ignored.
REQ-009 SHALL, for an accepted non-load, present wr_en=(ex_rd!=0), wr_addr=ex_rd, wr_data=ex_result on the cycle after acceptance (latency 1).
REQ-010 SHALL implement FSM IDLE/WAIT_LOAD; IDLE->WAIT_LOAD on accepted load; WAIT_LOAD->IDLE on the cycle i_dmem_rvalid=1.
REQ-011 SHALL drive o_wb_stall=1 for every cycle state=WAIT_LOAD, including the rvalid cycle; 0 in IDLE.
REQ-012 SHALL capture ex_rd, ex_funct3, ex_addr_lo on load acceptance and write the extended load value the cycle after rvalid.
REQ-013 SHALL extend loads: funct3 0 LB sign byte, 1 LH sign half, 2 LW, 4 LBU zero byte, 5 LHU zero half; byte lane = addr_lo, half lane = addr_lo[1].
REQ-014 SHALL, for funct3 3/6/7, write 0 to rd and set o_err.
REQ-015 SHALL set o_err on i_dmem_rvalid=1 in IDLE; that data is discarded.
REQ-016 SHALL drive of1_reg=wr_addr, of1_val=wr_data when wr_en=1, else of1_reg=0.
REQ-017 SHALL drive of2_reg/of2_val as the of1 pair delayed one cycle (covers regfile write-then-read).
REQ-018 SHALL never forward a pending load (of1_reg=0 while in WAIT_LOAD with no write).
REQ-019 SHALL increment o_retire_cnt once per completed writeback, including rd=0; wraps 0xFFFFFFFF->0.
REQ-020 SHALL keep o_err set until reset.

Reset
REQ-021 SHALL, on i_reset_n=0, asynchronously force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, of1/of2 reg and val=0, o_retire_cnt=0, o_err=0, o_wb_stall=0.
REQ-022 SHALL abandon an in-flight load on reset mid-WAIT_LOAD; no write occurs after deassertion.

Structure
REQ-023 SHALL place load funct3 encodings and FSM state typedef in shared package tiny_rv_pkg.
REQ-024 SHALL implement load alignment/extension as combinational sub-module tiny_rv_load_ext.

Verification
REQ-025 SHALL test ALU: ex_rd=5, ex_result=0x1234 accepted -> next cycle wr_en=1, wr_addr=5, of1=(5,0x1234); following cycle of2=(5,0x1234).
REQ-026 SHALL test LB: addr_lo=3, rdata=0x80FFFFFF, rvalid 3 cycles after accept -> stall 3 cycles, then wr_data=0xFFFFFF80, rd written once.
REQ-027 SHALL test LHU: addr_lo=2, rdata=0xBEEF0000 -> wr_data=0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-028 SHALL test rd=0: ALU to x0 -> wr_en=0, of1_reg=0, o_retire_cnt increments.
REQ-029 SHALL test errors: funct3=3 load -> wr_data=0, o_err=1; stray rvalid in IDLE -> o_err=1, no write.
REQ-030 SHALL test reset: i_reset_n low mid-WAIT_LOAD -> outputs zero immediately; later rvalid -> no write, o_err=1.
